// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable data width, parity and stop bits, fed by a
// small circular FIFO so queued words go out back-to-back with no idle gap.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 219,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              data_valid,
    input  logic [DATA_BITS-1:0]              data,
    output logic                              data_ready,
    output logic                              tx_data,
    output logic                              active,
    output logic                              tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              overflow
);
    // state    | meaning
    // S_IDLE   | line high, waiting for a queued word
    // S_START  | driving the start bit (0)
    // S_DATA   | shifting data bits out LSB first
    // S_PARITY | driving the parity bit
    // S_STOP   | driving stop bit(s); chains straight into the next frame if queued

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    logic [BIT_W-1:0]       bit_cnt;
    logic [IDX_W-1:0]       data_idx;
    logic                   stop_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   bit_end;
    logic                   last_stop;
    logic [DATA_BITS-1:0]   head;
    logic                   head_par;

    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign data_ready = !fifo_full;
    assign push       = data_valid && !fifo_full;
    assign bit_end    = (bit_cnt == BIT_W'(CLKS_PER_BIT - 1));
    assign last_stop  = (stop_idx == 1'(STOP_BITS - 1));
    assign head       = mem[rd_ptr];
    assign head_par   = (PARITY == 1) ? ~^head : ^head;

    // The FSM pops exactly when it launches a frame: from idle, or at the end of the last stop bit.
    assign pop = !fifo_empty &&
                 ((state == S_IDLE) || (state == S_STOP && bit_end && last_stop));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= data_valid && fifo_full;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            data_idx <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx_data  <= 1'b1;
            active   <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
            case (state)
                S_IDLE: begin
                    bit_cnt <= '0;
                    if (pop) begin
                        state   <= S_START;
                        shreg   <= head;
                        par_bit <= head_par;
                        tx_data <= 1'b0;
                        active  <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state    <= S_DATA;
                        data_idx <= '0;
                        tx_data  <= shreg[0];
                        shreg    <= shreg >> 1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (data_idx == IDX_W'(DATA_BITS - 1)) begin
                            if (PARITY != 0) begin
                                state   <= S_PARITY;
                                tx_data <= par_bit;
                            end else begin
                                state    <= S_STOP;
                                stop_idx <= 1'b0;
                                tx_data  <= 1'b1;
                            end
                        end else begin
                            data_idx <= data_idx + 1'b1;
                            tx_data  <= shreg[0];
                            shreg    <= shreg >> 1;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state    <= S_STOP;
                        stop_idx <= 1'b0;
                        tx_data  <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            tx_done <= 1'b1;
                            if (pop) begin
                                state   <= S_START;
                                shreg   <= head;
                                par_bit <= head_par;
                                tx_data <= 1'b0;
                            end else begin
                                state   <= S_IDLE;
                                tx_data <= 1'b1;
                                active  <= 1'b0;
                            end
                        end else begin
                            stop_idx <= stop_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    tx_data <= 1'b1;
                    active  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboarded bench for uart_tx_fifo: four instances cover default 8N1, 7E2, 7O2 and 9N1;
// line monitors decode frames and compare them against expected words queued at write time.
module tb_uart_tx_fifo;
    localparam int CPB  = 219;
    localparam int HALF = CPB / 2;

    typedef struct packed {
        logic [8:0] w;
        logic       p;
    } exp_t;

    logic clk;
    logic rst0, rst_s;
    logic v0, v1, v2, v3;
    logic [7:0] d0;
    logic [6:0] d1, d2;
    logic [8:0] d3;
    logic ready0, ready1, ready2, ready3;
    logic tx0, tx1, tx2, tx3;
    logic act0, act1, act2, act3;
    logic done0, done1, done2, done3;
    logic ovf0, ovf1, ovf2, ovf3;
    logic [2:0] cnt0, cnt1, cnt2, cnt3;

    logic [3:0] tx_v, act_v, done_v, rst_v;
    assign tx_v   = {tx3, tx2, tx1, tx0};
    assign act_v  = {act3, act2, act1, act0};
    assign done_v = {done3, done2, done1, done0};
    assign rst_v  = {rst_s, rst_s, rst_s, rst0};

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   done_cnt [4];
    int   b2b [4];
    bit   go = 0;
    bit   side_done = 0;
    exp_t sb0 [$];
    exp_t sb1 [$];
    exp_t sb2 [$];
    exp_t sb3 [$];

    uart_tx_fifo u0 (.clk(clk), .reset(rst0), .data_valid(v0), .data(d0), .data_ready(ready0),
        .tx_data(tx0), .active(act0), .tx_done(done0), .fifo_count(cnt0), .overflow(ovf0));
    uart_tx_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (.clk(clk), .reset(rst_s),
        .data_valid(v1), .data(d1), .data_ready(ready1), .tx_data(tx1), .active(act1),
        .tx_done(done1), .fifo_count(cnt1), .overflow(ovf1));
    uart_tx_fifo #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u2 (.clk(clk), .reset(rst_s),
        .data_valid(v2), .data(d2), .data_ready(ready2), .tx_data(tx2), .active(act2),
        .tx_done(done2), .fifo_count(cnt2), .overflow(ovf2));
    uart_tx_fifo #(.DATA_BITS(9)) u3 (.clk(clk), .reset(rst_s), .data_valid(v3), .data(d3),
        .data_ready(ready3), .tx_data(tx3), .active(act3), .tx_done(done3),
        .fifo_count(cnt3), .overflow(ovf3));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 4; i++) begin
            done_cnt[i] = 0;
            b2b[i] = 0;
        end
    end
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done_v[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_exp(input int i, output exp_t e, output bit ok);
        ok = 1'b1;
        e  = '0;
        case (i)
            0: if (sb0.size() > 0) e = sb0.pop_front(); else ok = 1'b0;
            1: if (sb1.size() > 0) e = sb1.pop_front(); else ok = 1'b0;
            2: if (sb2.size() > 0) e = sb2.pop_front(); else ok = 1'b0;
            default: if (sb3.size() > 0) e = sb3.pop_front(); else ok = 1'b0;
        endcase
    endtask

    // Advance to the negedge where cyc reaches c; bail out early if that instance's reset is seen.
    task automatic wait_until(input int i, input int c, output bit ab);
        ab = 1'b0;
        while (cyc < c && !ab) begin
            @(negedge clk);
            if (rst_v[i] === 1'b1) ab = 1'b1;
        end
    endtask

    task automatic monitor(input int i, input int nb, input int par, input int nstop);
        int         n;
        int         s;
        bit         ab;
        bit         have_start;
        bit         found;
        bit         ok;
        exp_t       e;
        logic [12:0] rx;
        logic [12:0] eb;
        logic [8:0]  w;
        n = 1 + nb + ((par != 0) ? 1 : 0) + nstop;
        have_start = 1'b0;
        s = 0;
        forever begin
            if (!have_start) begin
                do @(negedge clk); while (!(tx_v[i] === 1'b0 && rst_v[i] === 1'b0));
                s = cyc;
            end
            have_start = 1'b0;
            ab = 1'b0;
            rx = '0;
            for (int k = 0; k < n && !ab; k++) begin
                wait_until(i, s + k * CPB + HALF, ab);
                if (!ab) rx[k] = tx_v[i];
            end
            if (ab) continue;
            pop_exp(i, e, ok);
            chk($sformatf("u%0d frame_expected", i), ok, 1);
            if (!ok) continue;
            eb = '0;
            for (int j = 0; j < nb; j++) eb[1 + j] = e.w[j];
            if (par != 0) eb[1 + nb] = e.p;
            for (int j = 0; j < nstop; j++) eb[1 + nb + ((par != 0) ? 1 : 0) + j] = 1'b1;
            w = '0;
            for (int j = 0; j < nb; j++) w[j] = rx[1 + j];
            chk($sformatf("u%0d data", i), w, e.w);
            chk($sformatf("u%0d frame_bits", i), rx, eb);
            found = 1'b0;
            for (int t = 0; t < CPB && !ab && !found; t++) begin
                wait_until(i, cyc + 1, ab);
                if (!ab && done_v[i] === 1'b1) found = 1'b1;
            end
            if (ab) continue;
            chk($sformatf("u%0d done_seen", i), found, 1);
            if (!found) continue;
            chk($sformatf("u%0d done_time", i), cyc - s, n * CPB);
            if (tx_v[i] === 1'b0) begin
                have_start = 1'b1;
                s = cyc;
                b2b[i]++;
            end
            chk($sformatf("u%0d active_after_frame", i), act_v[i], have_start);
            wait_until(i, cyc + 1, ab);
            if (!ab) chk($sformatf("u%0d done_width", i), done_v[i], 0);
        end
    endtask

    initial monitor(0, 8, 0, 1);
    initial monitor(1, 7, 2, 2);
    initial monitor(2, 7, 1, 2);
    initial monitor(3, 9, 0, 1);

    // Present a word for one edge; returns #1 after that edge with data_valid still high.
    task automatic send0(input logic [7:0] w, input bit accept);
        exp_t e;
        v0 = 1'b1;
        d0 = w;
        chk($sformatf("ready_before_%02h", w), ready0, accept);
        if (accept) begin
            e.w = {1'b0, w};
            e.p = 1'b0;
            sb0.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done0(input int target, input int limit);
        int n;
        n = 0;
        while (done_cnt[0] < target && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("u0 done_count", done_cnt[0], target);
    endtask

    initial begin
        exp_t e;
        wait (go);
        v1 = 1'b1; d1 = 7'h41;
        v2 = 1'b1; d2 = 7'h41;
        v3 = 1'b1; d3 = 9'h1FF;
        e.w = 9'h041; e.p = 1'b0; sb1.push_back(e);
        e.w = 9'h041; e.p = 1'b1; sb2.push_back(e);
        e.w = 9'h1FF; e.p = 1'b0; sb3.push_back(e);
        @(posedge clk);
        #1;
        v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        for (int n = 0; n < 3000 && (done_cnt[1] < 1 || done_cnt[2] < 1 || done_cnt[3] < 1); n++) begin
            @(posedge clk);
            #1;
        end
        chk("u1 done_count", done_cnt[1], 1);
        chk("u2 done_count", done_cnt[2], 1);
        chk("u3 done_count", done_cnt[3], 1);
        chk("u1 idle_line", tx1, 1);
        chk("u3 active_low", act3, 0);
        chk("side sb_drained", sb1.size() + sb2.size() + sb3.size(), 0);
        side_done = 1'b1;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int b2b_base;
        int n0;
        int s;
        int bad;
        rst0 = 1'b1; rst_s = 1'b1;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst tx_data", tx0, 1);
        chk("rst active", act0, 0);
        chk("rst tx_done", done0, 0);
        chk("rst overflow", ovf0, 0);
        chk("rst fifo_count", cnt0, 0);
        chk("rst data_ready", ready0, 1);
        chk("rst u1 tx_data", tx1, 1);
        rst0 = 1'b0; rst_s = 1'b0;
        @(posedge clk);
        #1;
        go = 1'b1;

        // single word 0xA5
        send0(8'hA5, 1'b1);
        v0 = 1'b0;
        chk("lat fifo_count_1", cnt0, 1);
        chk("lat tx_still_high", tx0, 1);
        @(posedge clk);
        #1;
        chk("lat tx_start_low", tx0, 0);
        chk("lat fifo_count_0", cnt0, 0);
        chk("lat active_high", act0, 1);
        wait_done0(1, 2400);
        chk("a5 active_fell", act0, 0);
        chk("a5 line_idle", tx0, 1);
        chk("a5 sb_drained", sb0.size(), 0);

        // burst of five plus one overflow
        base = done_cnt[0];
        b2b_base = b2b[0];
        send0(8'h00, 1'b1);
        send0(8'hFF, 1'b1);
        send0(8'h55, 1'b1);
        send0(8'hAA, 1'b1);
        send0(8'h3C, 1'b1);
        send0(8'h77, 1'b0);
        v0 = 1'b0;
        chk("burst overflow_pulse", ovf0, 1);
        chk("burst fifo_count_full", cnt0, 4);
        @(posedge clk);
        #1;
        chk("burst overflow_clear", ovf0, 0);
        wait_done0(base + 5, 5 * 10 * CPB + 600);
        chk("burst back_to_back", b2b[0] - b2b_base, 4);
        repeat (300) @(posedge clk);
        #1;
        chk("burst no_sixth_frame", done_cnt[0], base + 5);
        chk("burst sb_drained", sb0.size(), 0);

        // reset in the middle of data bit 3 with two words queued
        base = done_cnt[0];
        send0(8'h12, 1'b1);
        n0 = cyc;
        send0(8'h34, 1'b1);
        send0(8'h56, 1'b1);
        v0 = 1'b0;
        s = n0 + 1;
        bad = 0;
        while (cyc < s + 4 * CPB + HALF && bad < 5000) begin
            @(posedge clk);
            #1;
            bad++;
        end
        chk("prerst active", act0, 1);
        chk("prerst fifo_count", cnt0, 2);
        chk("prerst data_bit3", tx0, 0);
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst tx_data", tx0, 1);
        chk("midrst active", act0, 0);
        chk("midrst fifo_count", cnt0, 0);
        chk("midrst data_ready", ready0, 1);
        chk("midrst tx_done", done0, 0);
        rst0 = 1'b0;
        sb0.delete();
        bad = 0;
        repeat (800) begin
            @(posedge clk);
            #1;
            if (tx0 !== 1'b1 || act0 !== 1'b0) bad++;
        end
        chk("postrst line_high", bad, 0);
        chk("postrst no_done", done_cnt[0], base);

        send0(8'h81, 1'b1);
        v0 = 1'b0;
        wait_done0(base + 1, 2400);
        chk("recover sb_drained", sb0.size(), 0);

        for (int n = 0; n < 3000 && !side_done; n++) @(posedge clk);
        chk("side finished", side_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised successor to the fixed 8N1 uart_tx. It serialises words for the audio-visualiser host link, with configurable data width, parity and stop bits. A small input FIFO absorbs bursts of samples, so frames are sent back-to-back with no idle gap. It sits between the sample/feature packer and the board TX pin.

Parameters:
CLKS_PER_BIT, 219, clock cycles per UART bit (25.2 MHz / 115200); must be ≥ 2.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
FIFO_DEPTH, 4, input FIFO entries; power of two, ≥ 2.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous reset, active-high.
data_valid  in  1  write request; a word is accepted on a rising edge where data_valid & data_ready.
data  in  DATA_BITS  word to transmit.
data_ready  out  1  high when the FIFO is not full.
tx_data  out  1  serial line; idle high; registered.
active  out  1  high while a frame is on the line (START through last STOP).
tx_done  out  1  one-cycle pulse on completion of each frame.
fifo_count  out  $clog2(FIFO_DEPTH+1)  number of words queued, excluding the word currently being sent.
overflow  out  1  one-cycle pulse when data_valid is high while the FIFO is full; that word is dropped.

Behaviour:
- Reset values: tx_data = 1, active = 0, tx_done = 0, overflow = 0, fifo_count = 0, data_ready = 1. FSM goes to IDLE and the FIFO is flushed.
- Reset mid-frame aborts the frame at that edge; the line returns high immediately.
- FIFO: circular buffer with read and write pointers. data_ready = (fifo_count != FIFO_DEPTH).
- Simultaneous push and pop is allowed; fifo_count is then unchanged.
- When full: data_ready = 0, and no push occurs even if a pop happens in the same cycle.
- Frame format: 1 start bit (0), DATA_BITS data bits LSB first, an optional parity bit, then STOP_BITS stop bits (1).
  - Parity covers the data bits only: odd → data XOR-reduce inverted; even → XOR-reduce.
- FSM states: IDLE, START, DATA, PARITY, STOP. Each bit lasts exactly CLKS_PER_BIT cycles, timed by a bit counter 0..CLKS_PER_BIT-1.
  - IDLE → START when the FIFO is non-empty. On that edge the FSM pops the head into the shift register, drives tx_data = 0 and sets active = 1.
  - START → DATA after 1 bit period.
  - DATA → PARITY, or → STOP when PARITY = 0, after DATA_BITS periods. A data-bit index counter advances each period.
  - PARITY → STOP after 1 period.
  - STOP → after STOP_BITS periods:
    - FIFO non-empty: go directly to START (pop, tx_data = 0, active stays 1).
    - FIFO empty: go to IDLE (tx_data = 1, active = 0).
- tx_done is high for the single cycle following the edge that ends the final stop bit, in both exit cases.
- Latency: a word accepted at edge N into an empty FIFO with the FSM in IDLE produces tx_data = 0 from edge N+1. fifo_count reads 1 for one cycle, then 0.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) × CLKS_PER_BIT cycles, exact. With back-to-back frames there is zero gap between one frame's last stop bit and the next start bit.
- A word written while a frame is in flight never alters the frame on the line.

Test Plan:
- Defaults, single word 0xA5 → tx_data low 1 cycle after acceptance; bits sampled mid-period read 1,0,1,0,0,1,0,1 then stop = 1; tx_done pulses once, exactly 10×219 cycles after start fall; active then falls.
- Burst of 5 words 0x00, 0xFF, 0x55, 0xAA, 0x3C at one per cycle, FIFO_DEPTH = 4 → first 5 accepted (1 goes straight to the FSM, 4 queue) and data_ready falls. All decoded in order, back-to-back with no high gap between frames beyond the stop bit, 5 tx_done pulses.
- Sixth write while full → overflow pulses for 1 cycle, the word is dropped, and the decoded stream still contains only the 5 words.
- PARITY = 2, STOP_BITS = 2, DATA_BITS = 7, word 0x41 → parity bit 0; two stop periods; frame is 11×219 cycles. Same word with PARITY = 1 → parity bit 1.
- DATA_BITS = 9, word 0x1FF → 9 ones after the start bit.
- Reset asserted at mid-data bit 3 with 2 words queued → tx_data = 1, active = 0, fifo_count = 0 on the next edge; no tx_done pulse; the line stays high until a new write.
